gate_bus_checker: RTL and testbench
===================================

// Module: gate_bus_checker
//
// PURPOSE
//   Stimulus-and-readback end of the 6-bit logic-gate result bus.
//   - Drives the two gate inputs (a, b) through all four combinations.
//   - Waits a programmable settle time, samples the returned bus and compares it
//     against expected {xnor, xor, and, or, not a, not a}.
//   - Reports pass/fail, an error count and per-combination fail flags.
//   - Sits beside the gate array as its built-in self-test sequencer.
//
// PARAMETERS
//   SETTLE_CYCLES  2  idle cycles between driving a vector and sampling res_bus (>=0)
//   NUM_PASSES     1  full 4-vector sweeps per start (>=1)
//   ERR_CNT_W      4  width of err_cnt; counter saturates at all-ones
//
// PORTS
//   clk       in   1          single clock, rising edge
//   rst_n     in   1          asynchronous, active-low reset
//   start     in   1          begin a run; sampled only in IDLE
//   drv_a     out  1          gate input a (registered)
//   drv_b     out  1          gate input b (registered)
//   res_bus   in   6          gate results [0]=~a [1]=~a [2]=a|b [3]=a&b [4]=a^b [5]=~(a^b)
//   busy      out  1          high in DRIVE/SETTLE/SAMPLE
//   done      out  1          one-cycle pulse in DONE
//   pass      out  1          err_cnt==0 at end of run; held until next start
//   err_cnt   out  ERR_CNT_W  mismatching samples this run, saturating
//   fail_vec  out  4          sticky; bit i set if combination i={a,b} ever mismatched
//
// BEHAVIOUR
//   - Reset (async, rst_n=0): every output 0, state IDLE, indices and counters 0.
//   - FSM: IDLE -> DRIVE -> SETTLE (SETTLE_CYCLES cycles; skipped if 0) -> SAMPLE
//          -> DRIVE for next vector, or -> DONE after last vector of last pass.
//          DONE -> IDLE unconditionally.
//   - IDLE + start=1: clear err_cnt, fail_vec, pass; vec_idx=0, pass_idx=0.
//     Go to DRIVE; drv_a/drv_b load vec_idx[1]/vec_idx[0] on this edge.
//   - Vector order per pass: {a,b} = 00, 01, 10, 11; vec_idx wraps 3->0 and
//     increments pass_idx.
//   - Timing: each vector occupies SETTLE_CYCLES+2 cycles.
//     busy lasts NUM_PASSES*4*(SETTLE_CYCLES+2) cycles.
//     done is high the cycle after the final SAMPLE; busy is low in DONE.
//   - SAMPLE: compare res_bus against expected for the currently driven (drv_a, drv_b).
//     On any bit mismatch:
//       - err_cnt += 1, saturating at 2^ERR_CNT_W-1;
//       - fail_vec[vec_idx] <= 1.
//     A mismatch counts once per sample, regardless of how many bits differ.
//   - pass: registered on entry to DONE as (final err_cnt==0); stable until next accepted start.
//   - drv_a/drv_b: hold last vector (11) after DONE until next start or reset.
//   - start while busy or in DONE: ignored, with no side effects.
//     A start held high continuously retriggers only from IDLE.
//   - Reset mid-run: immediate return to IDLE with all outputs 0.
//     No partial results retained.
//   - err_cnt saturation never wraps; fail_vec continues to update after saturation.
//
// STRUCTURE
//   - Package gate_check_pkg holds:
//       - typedef enum state_t {IDLE, DRIVE, SETTLE, SAMPLE, DONE};
//       - localparam RES_W=6 and NUM_VECTORS=4;
//       - function automatic expected_bus(a, b) returning logic [RES_W-1:0].
//   - One sub-module, gate_expect: combinational (a, b) -> expected 6-bit bus wrapping
//     expected_bus().
//   - Everything else (FSM, settle counter, vec/pass indices, error logic) stays in this module.
//
// TESTING
//   1. Reset: rst_n=0 with start=1 -> all outputs 0; after release no activity until start
//      is sampled in IDLE.
//   2. Golden gate model, defaults, start pulse:
//      - drv {a,b} = 00,01,10,11, each held 4 cycles;
//      - busy high 16 cycles, done pulse on cycle 17;
//      - pass=1, err_cnt=0, fail_vec=0000.
//   3. res_bus[3] stuck at 0:
//      - only combination 11 fails;
//      - err_cnt=1, fail_vec=1000, pass=0.
//   4. res_bus fully inverted, NUM_PASSES=2, ERR_CNT_W=2:
//      - 8 mismatches, err_cnt saturates at 3;
//      - fail_vec=1111, pass=0.
//   5. rst_n pulsed low during SETTLE of vector 10:
//      - outputs 0 asynchronously;
//      - a fresh start with golden model gives pass=1, err_cnt=0.
//   6. SETTLE_CYCLES=0, start held high throughout:
//      - busy high 8 cycles, done pulse;
//      - a new run begins the cycle after DONE;
//      - err_cnt/fail_vec cleared at that start.

Source files
------------

// File: rtl/gate_check_pkg.sv
// gate_check_pkg: shared types, sizes and golden gate function for the gate-bus self-test
package gate_check_pkg;
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;
  localparam int RES_W = 6;
  localparam int NUM_VECTORS = 4;
  function automatic logic [RES_W-1:0] expected_bus(input logic a, input logic b);
    return {~(a ^ b), a ^ b, a & b, a | b, ~a, ~a};
  endfunction
endpackage

// File: rtl/gate_expect.sv
// gate_expect: combinational golden result bus for the currently driven gate inputs
module gate_expect
  import gate_check_pkg::*;
(
  input  logic             a,
  input  logic             b,
  output logic [RES_W-1:0] exp_bus
);
  assign exp_bus = expected_bus(a, b);
endmodule

// File: rtl/gate_bus_checker.sv
// gate_bus_checker: drives all gate input combinations, samples the result bus and tallies mismatches
module gate_bus_checker
  import gate_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 drv_a,
  output logic                 drv_b,
  input  logic [RES_W-1:0]     res_bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [3:0]           fail_vec
);
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = NUM_PASSES > 1 ? $clog2(NUM_PASSES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
  localparam logic [PW-1:0] PASS_LAST = PW'(NUM_PASSES - 1);
  state_t                 state, state_nx;
  logic [SW-1:0]          settle_cnt;
  logic [1:0]             vec_idx;
  logic [PW-1:0]          pass_idx;
  logic [RES_W-1:0]       exp_bus;
  logic                   mismatch, last_vec;
  logic [ERR_CNT_W-1:0]   err_nx;
  gate_expect u_expect (.a(drv_a), .b(drv_b), .exp_bus(exp_bus));
  assign mismatch = res_bus != exp_bus;
  assign last_vec = vec_idx == 2'(NUM_VECTORS - 1) && pass_idx == PASS_LAST;
  assign err_nx   = (mismatch && err_cnt != '1) ? err_cnt + ERR_CNT_W'(1) : err_cnt;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next-state: one vector is DRIVE, optional SETTLE run, then SAMPLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? DRIVE : IDLE;
      DRIVE:   state_nx = SETTLE_CYCLES == 0 ? SAMPLE : SETTLE;
      SETTLE:  state_nx = settle_cnt == SETTLE_LAST ? SAMPLE : SETTLE;
      SAMPLE:  state_nx = last_vec ? DONE : DRIVE;
      default: state_nx = IDLE;
    endcase
  end
  // status outputs decoded from state
  always_comb begin
    busy = state == DRIVE || state == SETTLE || state == SAMPLE;
    done = state == DONE;
  end
  // vector sequencing, settle timing and result accumulation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      drv_a      <= 1'b0;
      drv_b      <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_vec   <= '0;
      settle_cnt <= '0;
      vec_idx    <= '0;
      pass_idx   <= '0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            drv_a    <= 1'b0;
            drv_b    <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= '0;
            vec_idx  <= '0;
            pass_idx <= '0;
          end
        DRIVE:  settle_cnt <= '0;
        SETTLE: settle_cnt <= settle_cnt + SW'(1);
        SAMPLE: begin
          err_cnt <= err_nx;
          if (mismatch) fail_vec[vec_idx] <= 1'b1;
          if (last_vec) pass <= err_nx == '0;
          else begin
            vec_idx        <= vec_idx + 2'd1;
            {drv_a, drv_b} <= vec_idx + 2'd1;
            if (vec_idx == 2'd3) pass_idx <= pass_idx + PW'(1);
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_gate_bus_checker.sv
// tb_gate_bus_checker: randomized fault injection on the result bus against a sweep-level model
module tb_gate_bus_checker;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start [3];
  logic       drv_a [3];
  logic       drv_b [3];
  logic       busy  [3];
  logic       done  [3];
  logic       pass  [3];
  logic [5:0] res   [3];
  logic [3:0] fv    [3];
  logic [5:0] mask  [3][4];
  logic [3:0] err0, err2;
  logic [1:0] err1;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         e_old;

  always #5 clk = ~clk;

  gate_bus_checker u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .drv_a(drv_a[0]), .drv_b(drv_b[0]),
    .res_bus(res[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_cnt(err0), .fail_vec(fv[0]));
  gate_bus_checker #(.NUM_PASSES(2), .ERR_CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .drv_a(drv_a[1]), .drv_b(drv_b[1]),
    .res_bus(res[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_cnt(err1), .fail_vec(fv[1]));
  gate_bus_checker #(.SETTLE_CYCLES(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .drv_a(drv_a[2]), .drv_b(drv_b[2]),
    .res_bus(res[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_cnt(err2), .fail_vec(fv[2]));

  function automatic logic [5:0] gold(input logic a, input logic b);
    int ia = int'(a);
    int ib = int'(b);
    logic [5:0] r;
    r[0] = ia == 0;
    r[1] = ia == 0;
    r[2] = (ia + ib) > 0;
    r[3] = (ia * ib) == 1;
    r[4] = ((ia + ib) % 2) == 1;
    r[5] = ((ia + ib) % 2) == 0;
    return r;
  endfunction

  // gate array stand-in: golden gates with a per-combination fault mask
  always_comb
    for (int i = 0; i < 3; i++) res[i] = gold(drv_a[i], drv_b[i]) ^ mask[i][{drv_a[i], drv_b[i]}];

  function automatic logic [3:0] errv(input int i);
    return i == 0 ? err0 : i == 1 ? {2'b00, err1} : err2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_masks(input int i, input logic [5:0] m0, m1, m2, m3);
    mask[i][0] = m0; mask[i][1] = m1; mask[i][2] = m2; mask[i][3] = m3;
  endtask

  task automatic rand_masks(input int i);
    for (int v = 0; v < 4; v++)
      mask[i][v] = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
  endtask

  task automatic check_zero(input int i, input string tag);
    chk({tag, "_busy"}, 32'(busy[i]), 0);
    chk({tag, "_done"}, 32'(done[i]), 0);
    chk({tag, "_pass"}, 32'(pass[i]), 0);
    chk({tag, "_drv"}, 32'({drv_a[i], drv_b[i]}), 0);
    chk({tag, "_err"}, 32'(errv(i)), 0);
    chk({tag, "_fv"}, 32'(fv[i]), 0);
  endtask

  // called at the negedge of the first DRIVE cycle; returns at the DONE cycle
  task automatic check_run(input int i, input int passes, input int settle, input int w,
                           output int exp_e);
    int per = settle + 2;
    int total = passes * 4 * per;
    int bad = 0;
    int lim = (1 << w) - 1;
    logic [3:0] exp_f = 4'd0;
    for (int v = 0; v < 4; v++)
      if (mask[i][v] != 6'd0) begin
        bad += passes;
        exp_f[v] = 1'b1;
      end
    exp_e = bad > lim ? lim : bad;
    for (int c = 0; c < total; c++) begin
      if (c > 0) @(negedge clk);
      chk("run_busy", 32'(busy[i]), 1);
      chk("run_done_low", 32'(done[i]), 0);
      chk("run_drv", 32'({drv_a[i], drv_b[i]}), 32'((c / per) % 4));
    end
    @(negedge clk);
    chk("end_done", 32'(done[i]), 1);
    chk("end_busy", 32'(busy[i]), 0);
    chk("end_err", 32'(errv(i)), 32'(exp_e));
    chk("end_fv", 32'(fv[i]), 32'(exp_f));
    chk("end_pass", 32'(pass[i]), 32'(exp_e == 0));
    chk("end_drv_hold", 32'({drv_a[i], drv_b[i]}), 3);
  endtask

  task automatic launch(input int i);
    @(negedge clk) start[i] = 1'b1;
    @(negedge clk) start[i] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b1;
      set_masks(i, 0, 0, 0, 0);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_zero(i, "reset");
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) check_zero(i, "idle");

    launch(0);
    check_run(0, 1, 2, 4, e_old);
    @(negedge clk);
    chk("done_pulse", 32'(done[0]), 0);
    chk("pass_hold", 32'(pass[0]), 1);

    set_masks(0, 0, 0, 0, 6'b001000);
    launch(0);
    check_run(0, 1, 2, 4, e_old);

    set_masks(1, 6'h3f, 6'h3f, 6'h3f, 6'h3f);
    launch(1);
    check_run(1, 2, 2, 2, e_old);

    for (int r = 0; r < 4; r++) begin
      rand_masks(0);
      launch(0);
      check_run(0, 1, 2, 4, e_old);
      rand_masks(1);
      launch(1);
      check_run(1, 2, 2, 2, e_old);
    end

    set_masks(0, 6'h01, 0, 0, 0);
    launch(0);
    repeat (9) @(negedge clk);
    chk("mid_drv", 32'({drv_a[0], drv_b[0]}), 2);
    chk("mid_err", 32'(errv(0)), 1);
    rst_n = 1'b0;
    #1;
    check_zero(0, "async_rst");
    @(negedge clk) rst_n = 1'b1;
    set_masks(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_zero(0, "post_rst");
    launch(0);
    check_run(0, 1, 2, 4, e_old);

    rand_masks(2);
    mask[2][1] = 6'h10;
    @(negedge clk) start[2] = 1'b1;
    @(negedge clk);
    check_run(2, 1, 0, 4, e_old);
    set_masks(2, 0, 0, 0, 0);
    @(negedge clk);
    chk("retrig_idle_busy", 32'(busy[2]), 0);
    chk("retrig_idle_err", 32'(errv(2)), 32'(e_old));
    @(negedge clk);
    chk("retrig_clr_err", 32'(errv(2)), 0);
    chk("retrig_clr_fv", 32'(fv[2]), 0);
    check_run(2, 1, 0, 4, e_old);
    start[2] = 1'b0;
    repeat (3) @(negedge clk);
    chk("retrig_stop", 32'(busy[2]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
